// File: rtl/uart_apb_cmd_ctrl.sv
// uart_apb_cmd_ctrl: parses 'W'/'R' command frames from the UART RX byte
// stream, issues one APB write/read per frame and returns a response.
// Ports: iCLK/iRESET (sync, active-high); iRX_DATA/iRX_VALID byte in;
// oTX_DATA/oTX_VALID/iTX_READY byte out; oAPB_WRITE/oAPB_READ strobes with
// oAPB_ADDR/oAPB_WDATA; iAPB_RDATA_EN/iAPB_RDATA read return;
// oBUSY (not IDLE); oRX_DROP (byte discarded).
// Optional: define UART_APB_CMD_CSUM_EN for a trailing XOR checksum byte.
module uart_apb_cmd_ctrl #(
  parameter int unsigned RD_TIMEOUT    = 255,
  parameter int unsigned FRAME_TIMEOUT = 10000
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic [7:0]  iRX_DATA,
  input  logic        iRX_VALID,
  output logic [7:0]  oTX_DATA,
  output logic        oTX_VALID,
  input  logic        iTX_READY,
  output logic        oAPB_WRITE,
  output logic        oAPB_READ,
  output logic [15:0] oAPB_ADDR,
  output logic [31:0] oAPB_WDATA,
  input  logic        iAPB_RDATA_EN,
  input  logic [31:0] iAPB_RDATA,
  output logic        oBUSY,
  output logic        oRX_DROP
);

  localparam logic [7:0] OP_WR    = 8'h57;
  localparam logic [7:0] OP_RD    = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_BAD  = 8'h3F;
  localparam logic [7:0] RSP_TO   = 8'h15;
  localparam logic [15:0] FT_LAST = 16'(FRAME_TIMEOUT - 1);
  localparam logic [7:0]  RT_LAST = 8'(RD_TIMEOUT - 1);
`ifdef UART_APB_CMD_CSUM_EN
  localparam logic [7:0] RSP_CSUM = 8'h21;
  // full addr+data kept until the checksum byte is judged
  localparam int SHW = 48;
`else
  // last data byte is taken straight from the input
  localparam int SHW = 40;
`endif

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
`ifdef UART_APB_CMD_CSUM_EN
    CHK,
`endif
    APB_WR,
    APB_RD,
    WAIT_RD,
    TX_RESP
  } stateT;

  stateT state, stateNxt;
  logic isWr, isWrNxt;
  logic [1:0] cnt, cntNxt;
  logic [SHW-1:0] shReg, shNxt;
  logic [47:0] shIn;
  logic [15:0] idleCnt, idleNxt;
  logic [7:0] rdCnt, rdCntNxt;
  logic [31:0] txBuf, txBufNxt;
  logic [2:0] txLeft, txLeftNxt;
  logic [15:0] addrReg, addrNxt;
  logic [31:0] wdataReg, wdataNxt;
  logic rxDrop, rxDropNxt;
  logic rxState;
`ifdef UART_APB_CMD_CSUM_EN
  logic [7:0] csum, csumNxt;
  assign rxState = state == GET_ADDR || state == GET_DATA
                || state == CHK;
`else
  assign rxState = state == GET_ADDR || state == GET_DATA;
`endif

  assign oTX_DATA   = txBuf[31:24];
  assign oTX_VALID  = state == TX_RESP;
  assign oAPB_WRITE = state == APB_WR;
  assign oAPB_READ  = state == APB_RD;
  assign oAPB_ADDR  = addrReg;
  assign oAPB_WDATA = wdataReg;
  assign oBUSY      = state != IDLE;
  assign oRX_DROP   = rxDrop;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state    <= IDLE;
      isWr     <= 1'b0;
      cnt      <= '0;
      shReg    <= '0;
      idleCnt  <= '0;
      rdCnt    <= '0;
      txBuf    <= '0;
      txLeft   <= '0;
      addrReg  <= '0;
      wdataReg <= '0;
      rxDrop   <= 1'b0;
`ifdef UART_APB_CMD_CSUM_EN
      csum     <= '0;
`endif
    end else begin
      state    <= stateNxt;
      isWr     <= isWrNxt;
      cnt      <= cntNxt;
      shReg    <= shNxt;
      idleCnt  <= idleNxt;
      rdCnt    <= rdCntNxt;
      txBuf    <= txBufNxt;
      txLeft   <= txLeftNxt;
      addrReg  <= addrNxt;
      wdataReg <= wdataNxt;
      rxDrop   <= rxDropNxt;
`ifdef UART_APB_CMD_CSUM_EN
      csum     <= csumNxt;
`endif
    end
  end

  always_comb begin
    stateNxt  = state;
    isWrNxt   = isWr;
    cntNxt    = cnt;
    shNxt     = shReg;
    idleNxt   = idleCnt;
    rdCntNxt  = rdCnt;
    txBufNxt  = txBuf;
    txLeftNxt = txLeft;
    addrNxt   = addrReg;
    wdataNxt  = wdataReg;
    shIn      = {shReg[39:0], iRX_DATA};
    rxDropNxt = iRX_VALID && !(rxState || state == IDLE);
`ifdef UART_APB_CMD_CSUM_EN
    csumNxt   = csum;
`endif
    // inter-byte watchdog; a byte always takes priority
    if (rxState) begin
      if (iRX_VALID)
        idleNxt = '0;
      else if (idleCnt == FT_LAST)
        stateNxt = IDLE;
      else
        idleNxt = idleCnt + 16'd1;
    end
    unique case (state)
      IDLE: if (iRX_VALID) begin
        if (iRX_DATA == OP_WR || iRX_DATA == OP_RD) begin
          stateNxt = GET_ADDR;
          isWrNxt  = iRX_DATA == OP_WR;
          cntNxt   = '0;
          idleNxt  = '0;
`ifdef UART_APB_CMD_CSUM_EN
          csumNxt  = iRX_DATA;
`endif
        end else begin
          stateNxt  = TX_RESP;
          txBufNxt  = {RSP_BAD, 24'h0};
          txLeftNxt = 3'd1;
        end
      end
      GET_ADDR: if (iRX_VALID) begin
        shNxt  = shIn[SHW-1:0];
        cntNxt = cnt + 2'd1;
`ifdef UART_APB_CMD_CSUM_EN
        csumNxt = csum ^ iRX_DATA;
`endif
        if (cnt == 2'd1) begin
          cntNxt = '0;
          if (isWr) begin
            stateNxt = GET_DATA;
          end else begin
`ifdef UART_APB_CMD_CSUM_EN
            stateNxt = CHK;
`else
            stateNxt = APB_RD;
            addrNxt  = shIn[15:0];
`endif
          end
        end
      end
      GET_DATA: if (iRX_VALID) begin
        shNxt  = shIn[SHW-1:0];
        cntNxt = cnt + 2'd1;
`ifdef UART_APB_CMD_CSUM_EN
        csumNxt = csum ^ iRX_DATA;
`endif
        if (cnt == 2'd3) begin
`ifdef UART_APB_CMD_CSUM_EN
          stateNxt = CHK;
`else
          stateNxt = APB_WR;
          addrNxt  = shIn[47:32];
          wdataNxt = shIn[31:0];
`endif
        end
      end
`ifdef UART_APB_CMD_CSUM_EN
      CHK: if (iRX_VALID) begin
        if (iRX_DATA == csum) begin
          if (isWr) begin
            stateNxt = APB_WR;
            addrNxt  = shReg[47:32];
            wdataNxt = shReg[31:0];
          end else begin
            stateNxt = APB_RD;
            addrNxt  = shReg[15:0];
          end
        end else begin
          stateNxt  = TX_RESP;
          txBufNxt  = {RSP_CSUM, 24'h0};
          txLeftNxt = 3'd1;
        end
      end
`endif
      APB_WR: begin
        stateNxt  = TX_RESP;
        txBufNxt  = {RSP_ACK, 24'h0};
        txLeftNxt = 3'd1;
      end
      APB_RD: begin
        stateNxt = WAIT_RD;
        // counts cycles since the strobe, so TX starts RD_TIMEOUT later
        rdCntNxt = 8'd1;
      end
      WAIT_RD: begin
        if (iAPB_RDATA_EN) begin
          stateNxt  = TX_RESP;
          txBufNxt  = iAPB_RDATA;
          txLeftNxt = 3'd4;
        end else if (rdCnt >= RT_LAST) begin
          stateNxt  = TX_RESP;
          txBufNxt  = {RSP_TO, 24'h0};
          txLeftNxt = 3'd1;
        end else begin
          rdCntNxt = rdCnt + 8'd1;
        end
      end
      TX_RESP: if (iTX_READY) begin
        txBufNxt  = {txBuf[23:0], 8'h0};
        txLeftNxt = txLeft - 3'd1;
        if (txLeft == 3'd1)
          stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_apb_cmd_ctrl.sv
// tb_uart_apb_cmd_ctrl: directed bench with scoreboard queues for APB
// strobes and TX bytes of uart_apb_cmd_ctrl.
module tb_uart_apb_cmd_ctrl;

  localparam int RT = 30;
  localparam int FT = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rxData = 8'h0;
  logic rxValid = 1'b0;
  logic txReady;
  logic rdEn = 1'b0;
  logic [31:0] rdData = 32'h0;
  int readyMode = 0;

  logic [7:0] oTX_DATA;
  logic oTX_VALID, oAPB_WRITE, oAPB_READ, oBUSY, oRX_DROP;
  logic [15:0] oAPB_ADDR;
  logic [31:0] oAPB_WDATA;

  int checks = 0;
  int errors = 0;
  int n;

  typedef struct {
    bit wr;
    logic [15:0] addr;
    logic [31:0] data;
  } apbT;

  apbT apbExp[$];
  logic [7:0] txExp[$];
  apbT monE;

  always #5 clk = ~clk;

  uart_apb_cmd_ctrl #(
    .RD_TIMEOUT(RT),
    .FRAME_TIMEOUT(FT)
  ) dut (
    .iCLK(clk),
    .iRESET(rst),
    .iRX_DATA(rxData),
    .iRX_VALID(rxValid),
    .oTX_DATA(oTX_DATA),
    .oTX_VALID(oTX_VALID),
    .iTX_READY(txReady),
    .oAPB_WRITE(oAPB_WRITE),
    .oAPB_READ(oAPB_READ),
    .oAPB_ADDR(oAPB_ADDR),
    .oAPB_WDATA(oAPB_WDATA),
    .iAPB_RDATA_EN(rdEn),
    .iAPB_RDATA(rdData),
    .oBUSY(oBUSY),
    .oRX_DROP(oRX_DROP)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rxData  = b;
    rxValid = 1'b1;
    step();
    rxValid = 1'b0;
  endtask

  task automatic sendFrame(input logic [55:0] f, input int len);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h0;
    for (int i = 0; i < len; i++) begin
      b = f[55-8*i -: 8];
      x = x ^ b;
      sendByte(b);
    end
`ifdef UART_APB_CMD_CSUM_EN
    sendByte(x);
`endif
  endtask

  task automatic pushApb(input bit wr, input logic [15:0] a,
                         input logic [31:0] d);
    apbT e;
    e.wr = wr;
    e.addr = a;
    e.data = d;
    apbExp.push_back(e);
  endtask

  task automatic waitIdle(input string tag, input int limit);
    int k = 0;
    @(negedge clk);
    while ((oBUSY || txExp.size() != 0 || apbExp.size() != 0)
           && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(k < limit), 32'd1);
  endtask

  initial begin
    txReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (readyMode == 0)
        txReady = 1'b1;
      else if (readyMode == 2)
        txReady = 1'b0;
      else
        txReady = $urandom_range(0, 2) != 0;
    end
  end

  always @(negedge clk) begin
    if (oAPB_WRITE || oAPB_READ) begin
      if (apbExp.size() == 0) begin
        check("apbSpurious", {30'h0, oAPB_WRITE, oAPB_READ}, 32'h0);
      end else begin
        monE = apbExp.pop_front();
        check("apbKind", {30'h0, oAPB_WRITE, oAPB_READ},
              monE.wr ? 32'h2 : 32'h1);
        check("apbAddr", 32'(oAPB_ADDR), 32'(monE.addr));
        if (monE.wr)
          check("apbWdata", oAPB_WDATA, monE.data);
      end
    end
    if (oTX_VALID) begin
      if (txExp.size() == 0) begin
        check("txSpurious", {24'h0, oTX_DATA}, 32'hFFFF_FFFF);
      end else begin
        check("txByte", 32'(oTX_DATA), 32'(txExp[0]));
        if (txReady)
          void'(txExp.pop_front());
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rstTxValid", 32'(oTX_VALID), 32'd0);
    check("rstTxData", 32'(oTX_DATA), 32'd0);
    check("rstWrite", 32'(oAPB_WRITE), 32'd0);
    check("rstRead", 32'(oAPB_READ), 32'd0);
    check("rstAddr", 32'(oAPB_ADDR), 32'd0);
    check("rstWdata", oAPB_WDATA, 32'd0);
    check("rstBusy", 32'(oBUSY), 32'd0);
    check("rstDrop", 32'(oRX_DROP), 32'd0);
    step();
    rst = 1'b0;
    step();

    rdData = 32'hBAD0_BAD0;
    rdEn = 1'b1;
    step();
    rdEn = 1'b0;
    @(negedge clk);
    check("idleRdEnIgnored", 32'(oBUSY), 32'd0);

    pushApb(1'b1, 16'h1234, 32'hDEAD_BEEF);
    txExp.push_back(8'h06);
    sendFrame(56'h57_1234_DEADBEEF, 7);
    @(negedge clk);
    check("wrLatency", 32'(oAPB_WRITE), 32'd1);
    waitIdle("wrDone", 50);

    readyMode = 1;
    pushApb(1'b0, 16'h0010, 32'h0);
    txExp.push_back(8'hCA);
    txExp.push_back(8'hFE);
    txExp.push_back(8'hF0);
    txExp.push_back(8'h0D);
    sendFrame({24'h52_0010, 32'h0}, 3);
    @(negedge clk);
    check("rdLatency", 32'(oAPB_READ), 32'd1);
    repeat (3) step();
    rdData = 32'hCAFE_F00D;
    rdEn = 1'b1;
    step();
    rdEn = 1'b0;
    waitIdle("rdDone", 200);
    readyMode = 0;

    pushApb(1'b0, 16'h0020, 32'h0);
    txExp.push_back(8'h15);
    sendFrame({24'h52_0020, 32'h0}, 3);
    @(negedge clk);
    check("rdLatencyTo", 32'(oAPB_READ), 32'd1);
    n = 0;
    while (!oTX_VALID && n < RT + 20) begin
      @(negedge clk);
      n++;
    end
    check("rdTimeoutCycles", 32'(n), 32'(RT));
    @(negedge clk);
    check("rdTimeoutIdle", 32'(oBUSY), 32'd0);
    waitIdle("rdTimeoutDone", 20);

    txExp.push_back(8'h3F);
    sendByte(8'h41);
    waitIdle("badOpcode", 20);

    sendByte(8'h57);
    sendByte(8'h12);
    repeat (FT) @(negedge clk);
    check("abortHold", 32'(oBUSY), 32'd1);
    @(negedge clk);
    check("abortIdle", 32'(oBUSY), 32'd0);

    readyMode = 2;
    step();
    step();
    txExp.push_back(8'h3F);
    sendByte(8'h41);
    sendByte(8'h57);
    @(negedge clk);
    check("dropPulse", 32'(oRX_DROP), 32'd1);
    check("dropTxHeld", 32'(oTX_VALID), 32'd1);
    @(negedge clk);
    check("dropOneCycle", 32'(oRX_DROP), 32'd0);
    readyMode = 0;
    waitIdle("dropDone", 20);

    pushApb(1'b0, 16'h0030, 32'h0);
    sendFrame({24'h52_0030, 32'h0}, 3);
    @(negedge clk);
    check("rdLatencyRst", 32'(oAPB_READ), 32'd1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midRstBusy", 32'(oBUSY), 32'd0);
    check("midRstTxValid", 32'(oTX_VALID), 32'd0);
    check("midRstRead", 32'(oAPB_READ), 32'd0);
    check("midRstAddr", 32'(oAPB_ADDR), 32'd0);
    check("midRstWdata", oAPB_WDATA, 32'd0);

    pushApb(1'b1, 16'h0004, 32'h1122_3344);
    txExp.push_back(8'h06);
    sendFrame(56'h57_0004_11223344, 7);
    waitIdle("postRstWrite", 50);

`ifdef UART_APB_CMD_CSUM_EN
    pushApb(1'b0, 16'h0010, 32'h0);
    txExp.push_back(8'h01);
    txExp.push_back(8'h02);
    txExp.push_back(8'h03);
    txExp.push_back(8'h04);
    sendByte(8'h52);
    sendByte(8'h00);
    sendByte(8'h10);
    sendByte(8'h42);
    @(negedge clk);
    check("csumGoodRead", 32'(oAPB_READ), 32'd1);
    step();
    rdData = 32'h0102_0304;
    rdEn = 1'b1;
    step();
    rdEn = 1'b0;
    waitIdle("csumGoodDone", 50);

    txExp.push_back(8'h21);
    sendByte(8'h52);
    sendByte(8'h00);
    sendByte(8'h10);
    sendByte(8'h00);
    waitIdle("csumBad", 30);
`endif

    check("queuesEmpty", 32'(apbExp.size() + txExp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
